// File: rtl/h_update_align_pkg.sv
// h_update_align_pkg: shared tile geometry, widths and FP16 constants
package h_update_align_pkg;
    localparam int DW = 16;
    localparam int H_TILE = 1;
    localparam int P_TILE = 1;
    localparam int N_TILE = 128;
    localparam int L = H_TILE * P_TILE * N_TILE;
    localparam int FIFO_DEPTH = 4;
    localparam int A_LAT = 4;
    localparam int NUM_TILES = 16;
    localparam int TW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam logic [DW-1:0] FP16_ZERO = 16'h0000;
    localparam logic [DW-1:0] FP16_ONE = 16'h3C00;
    function automatic int lane_idx(input int h, input int p, input int n);
        return (h * P_TILE + p) * N_TILE + n;
    endfunction
endpackage

// File: rtl/h_update_align_if.sv
// h_update_align_if: dBx/dAh tile inputs and hnew result bundle
interface h_update_align_if import h_update_align_pkg::*; #(
    parameter int W = L * DW,
    parameter int IW = TW
) ();
    logic dBx_valid_i;
    logic [W-1:0] dBx_i;
    logic dBx_ready_o;
    logic dAh_valid_i;
    logic [W-1:0] dAh_i;
    logic [W-1:0] hnew_o;
    logic valid_o;
    logic last_o;
    logic [IW-1:0] tile_idx_o;
    logic err_ovf_o;
    logic err_udf_o;
    modport master (
        output dBx_valid_i, dBx_i, dAh_valid_i, dAh_i,
        input dBx_ready_o, hnew_o, valid_o, last_o, tile_idx_o, err_ovf_o, err_udf_o
    );
    modport slave (
        input dBx_valid_i, dBx_i, dAh_valid_i, dAh_i,
        output dBx_ready_o, hnew_o, valid_o, last_o, tile_idx_o, err_ovf_o, err_udf_o
    );
endinterface

// File: rtl/fp16_add_wrapper.sv
// fp16_add_wrapper: pipelined FP16 adder, round-to-nearest-even, result holds between valids
module fp16_add_wrapper #(
    parameter int LAT = 4
) (
    input logic clk,
    input logic rst,
    input logic valid_in,
    input logic [15:0] a,
    input logic [15:0] b,
    output logic [15:0] result,
    output logic valid_out
);
    logic [LAT-1:0] v;
    logic [15:0] d [LAT];
    function automatic logic [15:0] fadd(input logic [15:0] a_in, input logic [15:0] b_in);
        logic [15:0] x, y;
        logic [5:0] e;
        logic [4:0] ey, dsh;
        logic [13:0] mx, my;
        logic [14:0] m;
        logic [11:0] r;
        logic swap;
        swap = b_in[14:0] > a_in[14:0];
        x = swap ? b_in : a_in;
        y = swap ? a_in : b_in;
        if (&x[14:10])
            return (|x[9:0] || (y[14:0] == x[14:0] && y[15] != x[15])) ? 16'h7e00 : x;
        e = {1'b0, |x[14:10] ? x[14:10] : 5'd1};
        ey = |y[14:10] ? y[14:10] : 5'd1;
        dsh = e[4:0] - ey;
        mx = {|x[14:10], x[9:0], 3'b0};
        my = {|y[14:10], y[9:0], 3'b0};
        my = dsh > 5'd13 ? {13'b0, |my} : (my >> dsh) | {13'b0, |(my & ((14'h1 << dsh) - 14'h1))};
        m = (x[15] == y[15]) ? {1'b0, mx} + {1'b0, my} : {1'b0, mx} - {1'b0, my};
        if (m[14]) begin
            m = {1'b0, m[14:2], m[1] | m[0]};
            e = e + 6'd1;
        end
        for (int i = 0; i < 13; i++) begin
            if (!m[13] && e > 6'd1) begin
                m = m << 1;
                e = e - 6'd1;
            end
        end
        if (m == 15'd0) return {x[15] & y[15], 15'd0};
        r = {1'b0, m[13:3]} + {11'd0, m[2] & (m[1] | m[0] | m[3])};
        if (r[11]) begin
            r = r >> 1;
            e = e + 6'd1;
        end
        if (e >= 6'd31) return {x[15], 15'h7c00};
        return {x[15], r[10] ? e[4:0] : 5'd0, r[9:0]};
    endfunction
    // stage 0 computes the sum; later stages advance only with their valid so the output holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
            for (int i = 0; i < LAT; i++) d[i] <= '0;
        end else begin
            v <= LAT'({v, valid_in});
            if (valid_in) d[0] <= fadd(a, b);
            for (int i = 1; i < LAT; i++) if (v[i-1]) d[i] <= d[i-1];
        end
    end
    assign result = d[LAT-1];
    assign valid_out = v[LAT-1];
endmodule

// File: rtl/tile_fifo.sv
// tile_fifo: tile-wide register FIFO with combinational head
module tile_fifo #(
    parameter int W = 16,
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic rst,
    input logic push,
    input logic pop,
    input logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [$clog2(DEPTH):0] count,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    assign dout = mem[rd_ptr];
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    // pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    // storage needs no reset; occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/h_update_align.sv
// h_update_align: aligns early dBx tiles with dAh tiles and adds them lane-wise into hnew
module h_update_align import h_update_align_pkg::*; (
    input logic clk,
    input logic rst,
    h_update_align_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic push, pop, byp, f_full, f_empty, err_ovf, err_udf;
    logic [CW-1:0] f_count;
    logic [L*DW-1:0] head, b_sel, sum;
    logic [L-1:0] lane_v;
    logic [TW-1:0] issue_idx;
    logic [TW-1:0] side_idx [A_LAT];
    logic [A_LAT-1:0] side_last;
    assign bus.dBx_ready_o = !f_full || bus.dAh_valid_i;
    assign push = bus.dBx_valid_i && bus.dBx_ready_o;
    assign pop = bus.dAh_valid_i && (!f_empty || push);
    assign byp = f_empty && push && bus.dAh_valid_i;
    assign b_sel = byp ? bus.dBx_i : head;
    tile_fifo #(.W(L * DW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(push && !byp), .pop(pop && !byp), .din(bus.dBx_i),
        .dout(head), .count(f_count), .full(f_full), .empty(f_empty)
    );
    for (genvar h = 0; h < H_TILE; h++) begin : g_h
        for (genvar p = 0; p < P_TILE; p++) begin : g_p
            for (genvar n = 0; n < N_TILE; n++) begin : g_n
                localparam int K = lane_idx(h, p, n);
                fp16_add_wrapper #(.LAT(A_LAT)) u_add (
                    .clk(clk), .rst(rst), .valid_in(pop), .a(bus.dAh_i[K*DW +: DW]),
                    .b(b_sel[K*DW +: DW]), .result(sum[K*DW +: DW]), .valid_out(lane_v[K])
                );
            end
        end
    end
    assign bus.hnew_o = sum;
    assign bus.valid_o = lane_v[0];
    assign bus.last_o = lane_v[0] && side_last[A_LAT-1];
    assign bus.tile_idx_o = side_idx[A_LAT-1];
    assign bus.err_ovf_o = err_ovf;
    assign bus.err_udf_o = err_udf;
    // issue-side tile counter; index and last flag travel beside the adder pipe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_idx <= '0;
            side_last <= '0;
            for (int i = 0; i < A_LAT; i++) side_idx[i] <= '0;
        end else begin
            if (pop) issue_idx <= (issue_idx == TW'(NUM_TILES - 1)) ? '0 : issue_idx + 1'b1;
            side_last <= A_LAT'({side_last, pop && issue_idx == TW'(NUM_TILES - 1)});
            side_idx[0] <= issue_idx;
            for (int i = 1; i < A_LAT; i++) side_idx[i] <= side_idx[i-1];
        end
    end
    // sticky error flags, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            if (bus.dBx_valid_i && !bus.dBx_ready_o) err_ovf <= 1'b1;
            if (bus.dAh_valid_i && !pop) err_udf <= 1'b1;
        end
    end
    // all lanes share one issue strobe, so their valids must never diverge
    always_ff @(posedge clk) begin
        if (!rst) assert (lane_v == {L{lane_v[0]}} && f_count <= CW'(FIFO_DEPTH))
            else $warning("h_update_align: lane valid skew or count overrun");
    end
endmodule

// File: tb/tb_h_update_align.sv
// tb_h_update_align: randomized scoreboard bench for the dBx/dAh alignment adder
`timescale 1ns/1ps
module tb_h_update_align;
    import h_update_align_pkg::*;
    localparam int W = L * DW;
    typedef struct { logic [W-1:0] data; int idx; bit last; int cyc; } exp_t;

    logic clk = 0;
    logic rst = 1;
    int checks = 0, errors = 0, cyc = 0, bad;
    exp_t sb[$];
    exp_t me;
    logic [W-1:0] mq[$];
    int m_idx = 0;
    bit m_ovf = 0, m_udf = 0;

    h_update_align_if bus();
    h_update_align dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [15:0] to_fp16(input int v);
        int a, msb;
        if (v == 0) return 16'h0000;
        a = v < 0 ? -v : v;
        msb = 0;
        for (int i = 0; i < 12; i++) if (a >= (1 << i)) msb = i;
        return {v < 0, 5'(15 + msb), 10'((a << (10 - msb)) & 'h3ff)};
    endfunction

    function automatic real from_fp16(input logic [15:0] f);
        int e;
        real r;
        e = (f[14:10] == 0) ? 1 : int'(f[14:10]);
        r = (f[14:10] == 0) ? real'(f[9:0]) : real'(f[9:0]) + 1024.0;
        for (int i = e; i < 25; i++) r = r / 2.0;
        for (int i = 25; i < e; i++) r = r * 2.0;
        return f[15] ? -r : r;
    endfunction

    function automatic logic [W-1:0] add_tiles(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] t;
        for (int k = 0; k < L; k++)
            t[k*DW +: DW] = to_fp16($rtoi(from_fp16(a[k*DW +: DW]) + from_fp16(b[k*DW +: DW])));
        return t;
    endfunction

    function automatic logic [W-1:0] rand_tile();
        logic [W-1:0] t;
        for (int k = 0; k < L; k++) t[k*DW +: DW] = to_fp16(int'($urandom_range(2000)) - 1000);
        return t;
    endfunction

    function automatic logic [W-1:0] const_tile(input logic [15:0] v);
        return {L{v}};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input bit dbv, input logic [W-1:0] dbx, input bit dav, input logic [W-1:0] dah);
        bit acc;
        logic [W-1:0] hd;
        exp_t e;
        bus.dBx_valid_i = dbv;
        bus.dBx_i = dbx;
        bus.dAh_valid_i = dav;
        bus.dAh_i = dah;
        @(negedge clk);
        check("dbx_ready", bus.dBx_ready_o, mq.size() < FIFO_DEPTH || dav);
        acc = dbv && (mq.size() < FIFO_DEPTH || dav);
        if (acc) mq.push_back(dbx);
        if (dbv && !acc) m_ovf = 1;
        if (dav) begin
            if (mq.size() > 0) begin
                hd = mq.pop_front();
                e.data = add_tiles(dah, hd);
                e.idx = m_idx;
                e.last = (m_idx == NUM_TILES - 1);
                e.cyc = cyc + A_LAT;
                sb.push_back(e);
                m_idx = (m_idx + 1) % NUM_TILES;
            end else m_udf = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, '0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 20) begin
            idle(1);
            n++;
        end
        check("drain_pending", sb.size(), 0);
    endtask

    task automatic chk_errs();
        check("err_ovf", bus.err_ovf_o, m_ovf);
        check("err_udf", bus.err_udf_o, m_udf);
    endtask

    task automatic clear_model();
        sb.delete();
        mq.delete();
        m_idx = 0;
        m_ovf = 0;
        m_udf = 0;
    endtask

    task automatic do_reset();
        bus.dBx_valid_i = 0;
        bus.dAh_valid_i = 0;
        @(negedge clk) rst = 1;
        clear_model();
        @(negedge clk) rst = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_valid"}, bus.valid_o, 0);
        check({tag, "_last"}, bus.last_o, 0);
        check({tag, "_idx"}, bus.tile_idx_o, 0);
        check({tag, "_hnew"}, |bus.hnew_o, 0);
        check({tag, "_count"}, dut.u_fifo.count, 0);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.valid_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got valid_o=1 idx %0d, expected no output", bus.tile_idx_o);
            end else begin
                me = sb.pop_front();
                bad = -1;
                for (int k = L - 1; k >= 0; k--) if (bus.hnew_o[k*DW +: DW] !== me.data[k*DW +: DW]) bad = k;
                checks++;
                if (bad >= 0) begin
                    errors++;
                    $display("FAIL hnew lane %0d: got %h expected %h", bad, bus.hnew_o[bad*DW +: DW], me.data[bad*DW +: DW]);
                end
                check("tile_idx", bus.tile_idx_o, me.idx);
                check("last", bus.last_o, me.last);
                check("latency_cycle", cyc, me.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.dBx_valid_i = 0;
        bus.dBx_i = '0;
        bus.dAh_valid_i = 0;
        bus.dAh_i = '0;
        repeat (2) @(posedge clk);
        chk_zero("in_reset");
        @(negedge clk) rst = 0;
        @(posedge clk);
        #1;
        chk_zero("post_reset");
        chk_errs();
        check("ready_reset", bus.dBx_ready_o, 1);

        step(1, const_tile(16'h4000), 0, '0);
        idle(2);
        step(0, '0, 1, const_tile(FP16_ONE));
        drain();
        check("single_pair_lane0", bus.hnew_o[15:0], 16'h4200);
        chk_errs();

        step(1, const_tile(FP16_ONE), 1, const_tile(FP16_ONE));
        check("bypass_count", dut.u_fifo.count, 0);
        drain();
        check("bypass_lane0", bus.hnew_o[15:0], 16'h4000);

        for (int i = 1; i <= 4; i++) step(1, const_tile(to_fp16(i)), 0, '0);
        check("fill_count", dut.u_fifo.count, 4);
        step(1, rand_tile(), 0, '0);
        chk_errs();
        for (int i = 0; i < 4; i++) step(0, '0, 1, const_tile(FP16_ZERO));
        drain();
        check("fill_last_lane0", bus.hnew_o[15:0], 16'h4400);

        do_reset();
        for (int i = 0; i < 4; i++) step(1, rand_tile(), 0, '0);
        for (int i = 0; i < 8; i++) begin
            step(1, rand_tile(), 1, rand_tile());
            check("full_pushpop_count", dut.u_fifo.count, 4);
        end
        for (int i = 0; i < 4; i++) step(0, '0, 1, rand_tile());
        drain();
        chk_errs();

        do_reset();
        step(0, '0, 1, rand_tile());
        idle(A_LAT + 2);
        chk_errs();
        step(1, rand_tile(), 0, '0);
        step(0, '0, 1, rand_tile());
        drain();

        do_reset();
        step(1, rand_tile(), 0, '0);
        for (int i = 0; i < NUM_TILES + 1; i++) step(1, rand_tile(), 1, rand_tile());
        step(0, '0, 1, rand_tile());
        drain();
        chk_errs();

        for (int i = 0; i < 300; i++)
            step($urandom_range(9) < 6, rand_tile(), $urandom_range(9) < 5, rand_tile());
        drain();
        chk_errs();

        do_reset();
        step(1, rand_tile(), 0, '0);
        for (int i = 0; i < 6; i++) step(1, rand_tile(), 1, rand_tile());
        bus.dBx_valid_i = 0;
        bus.dAh_valid_i = 0;
        #2 rst = 1;
        #1;
        chk_zero("async_reset");
        chk_errs();
        clear_model();
        @(negedge clk) rst = 0;
        @(posedge clk);
        #1;
        idle(10);
        step(1, rand_tile(), 1, rand_tile());
        drain();
        chk_errs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
